// File: rtl/muldiv_hilo_if.sv
// HI/LO execute-unit port bundle: op issue from ID/EX,
// HI/LO state and busy/done back to the pipeline.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid,
    output op_code,
    output a,
    output b,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  a,
    input  b,
    output busy,
    output done,
    output hi,
    output lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// HI/LO execute unit: iterative radix-2 shift-add multiply,
// madd/msub accumulate, mthi/mtlo, architectural HI/LO.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  muldiv_hilo_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_COMMIT
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [3:0]       op_q;
  logic             neg_q;
  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [W2-1:0]    prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_mul;
  logic             is_sgn;
  logic             is_mthi;
  logic             is_mtlo;
  logic             acc;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    step;
  logic [W2-1:0]    p;
  logic [W2-1:0]    hl;
  logic [W2-1:0]    res;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             s
  );
    return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  always_comb begin
    is_mul  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (bus.op_code)
      OP_MULT, OP_MADD, OP_MSUB, OP_MUL: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      OP_MULTU, OP_MADDU, OP_MSUBU: is_mul = 1'b1;
      OP_MTHI: is_mthi = 1'b1;
      OP_MTLO: is_mtlo = 1'b1;
      default: ;
    endcase
  end

  // Busy covers MUL and COMMIT, so accept is simply "idle and valid".
  assign acc   = bus.op_valid && (state == S_IDLE);
  assign mag_a = mag(bus.a, is_sgn);
  assign mag_b = mag(bus.b, is_sgn);

  assign step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign p    = neg_q ? (~prod_q + 1'b1) : prod_q;
  assign hl   = {hi_q, lo_q};

  always_comb begin
    res = p;
    unique case (1'b1)
      (op_q == OP_MADD) || (op_q == OP_MADDU): res = hl + p;
      (op_q == OP_MSUB) || (op_q == OP_MSUBU): res = hl - p;
      default: res = p;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (acc && is_mul) state_d = S_MUL;
      S_MUL:    if (cnt_q == LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc && is_mthi) hi_q <= bus.a;
          if (acc && is_mtlo) lo_q <= bus.a;
          if (acc && is_mul) begin
            op_q     <= bus.op_code;
            neg_q    <= is_sgn &
                        (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            prod_q   <= '0;
            cnt_q    <= '0;
          end
        end
        S_MUL: begin
          prod_q   <= step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        S_COMMIT: begin
          hi_q   <= res[W2-1:WIDTH];
          lo_q   <= res[WIDTH-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle execute-stage unit for the HI/LO instruction class emitted by the ID-stage decoder: mult, multu, madd, maddu, msub, msubu, mul, mthi and mtlo.
- Owns the architectural HI/LO registers and exposes them for mfhi/mflo readout on the mem_reg=011 writeback path.
- Uses an iterative radix-2 shift-add multiplier.
- Asserts busy so the hazard unit stalls any HI/LO consumer or new HI/LO op until the result commits.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- op_valid  input  1  op_code/a/b valid this cycle
- op_code  input  4  0 NONE, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 MTHI, 8 MTLO, 9 MUL; 10-15 treated as NONE
- a  input  WIDTH  rs operand (forwarded value)
- b  input  WIDTH  rt operand (forwarded value)
- busy  output  1  multiply in flight; new ops not accepted
- done  output  1  one-cycle pulse on the commit cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register; also the MUL rd result

Behaviour:
- Reset (rst=1 at a clk edge):
  - hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
  - Overrides everything, including a multiply in flight; the pending result is discarded.
- Accept: op is taken at an edge only when op_valid=1, busy=0 and op_code is 1..9. op_valid while busy=1 is ignored entirely; the pipeline must hold the instruction.
- MTHI/MTLO:
  - Single-cycle: hi<=a (or lo<=a) at the accept edge.
  - No busy, no done.
- Multiply ops (1-6, 9):
  - Accept edge: latch magnitude |a| and |b| (two's complement magnitude for signed ops 1, 3, 5, 9; raw for 2, 4, 6).
  - Accept edge: latch negate flag = a[WIDTH-1]^b[WIDTH-1] for signed ops, else 0.
  - Accept edge: clear the 2*WIDTH product accumulator and counter; state IDLE->MUL; busy=1 from the next cycle.
- MUL state:
  - Each edge, if multiplier LSB=1 add the multiplicand (shifted left by the iteration index) into the product; shift the multiplier right; counter++.
  - 0x80000000 signed has magnitude 0x80000000 unsigned; no special case is needed.
  - After WIDTH iterations, state MUL->COMMIT.
- COMMIT state (one edge):
  - p = negate ? -product : product (2*WIDTH-bit two's complement).
  - MULT/MULTU/MUL: {hi,lo}<=p.
  - MADD/MADDU: {hi,lo}<={hi,lo}+p.
  - MSUB/MSUBU: {hi,lo}<={hi,lo}-p.
  - All arithmetic is 2*WIDTH bits, wraps modulo 2^(2*WIDTH), and raises no overflow.
  - done=1 for the cycle after this edge; busy=0 from the same cycle; state->IDLE.
- Latency: accept at edge E0; busy high during cycles E0..E(WIDTH+1); hi/lo valid and done=1 after edge E(WIDTH+1), i.e. 33 edges for WIDTH=32.
- Next op may be accepted in the same cycle done=1.
- HI/LO never change while busy=1, because no MTHI/MTLO can be accepted then. MADD/MSUB therefore use the HI/LO value present at commit, which equals the value at accept.
- hi/lo outputs are direct register reads with no bypass; mfhi/mflo following a multiply must stall on busy.
- op_code NONE or 10-15 with op_valid=1: no state change.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
- MTHI a=1, then MTLO a=0xFFFFFFFF, then MADDU a=1 b=1 -> after the first two edges hi=1, lo=0xFFFFFFFF; after commit hi=2, lo=0. Then MSUB a=1 b=2 -> hi=1, lo=0xFFFFFFFE.
- MULT a=2 b=3 accepted, then MTLO a=7 and MULTU presented while busy=1 -> both ignored; commit gives hi=0, lo=6. Re-presenting MTLO on the done cycle -> lo=7 next edge.
- MULT in flight, rst=1 at iteration 10 -> hi=lo=0, busy=0 next cycle, no done. A following MUL a=4 b=-2 -> lo=0xFFFFFFF8, hi=0xFFFFFFFF.
- op_valid=1 with op_code=0 and op_code=12, a=0x1234 -> hi/lo/busy/done unchanged.
